scr1_pipe_mprf_wrarb: RTL and testbench
=======================================

// Module: scr1_pipe_mprf_wrarb
// PURPOSE
//  Controller for the single MPRF write port. Arbitrates EXU and LSU writeback
//  requests, with fixed LSU priority and an anti-starvation override for EXU.
//  Tracks outstanding-load destination registers in a busy scoreboard and flags
//  rs1/rs2 read hazards to EXU.
//  After reset, sequences a zero-fill sweep of x1..xN so the MPRF needs no reset.
//  Sits between EXU/LSU and scr1_pipe_mprf; the only master of exu2mprf_w_req/rd_*.
// PARAMETERS
//  MPRF_AW     5  MPRF address width; NREGS = 2**MPRF_AW (x0 never written)
//  XLEN        32 data width
//  STARVE_MAX  4  consecutive EXU losses before EXU is granted priority (1..15)
//  INIT_EN     1  1: zero-fill sweep after reset; 0: enter RUN directly
// PORTS
//  clk               in   1        core clock
//  rst               in   1        synchronous reset, active-high
//  exu2wa_req        in   1        EXU writeback valid
//  exu2wa_addr       in   MPRF_AW  EXU rd
//  exu2wa_data       in   XLEN     EXU rd data
//  wa2exu_rdy        out  1        EXU write accepted this cycle
//  lsu2wa_req        in   1        LSU load-return valid
//  lsu2wa_addr       in   MPRF_AW  LSU rd
//  lsu2wa_data       in   XLEN     LSU load data
//  wa2lsu_rdy        out  1        LSU write accepted this cycle
//  lsu2wa_rsv        in   1        load issued: reserve lsu2wa_rsv_addr
//  lsu2wa_rsv_addr   in   MPRF_AW  reserved destination
//  exu2wa_rs1_addr   in   MPRF_AW  rs1 probe
//  exu2wa_rs2_addr   in   MPRF_AW  rs2 probe
//  wa2exu_rs1_haz    out  1        rs1 busy (pending load)
//  wa2exu_rs2_haz    out  1        rs2 busy (pending load)
//  wa2mprf_w_req     out  1        MPRF write request
//  wa2mprf_rd_addr   out  MPRF_AW  MPRF write address
//  wa2mprf_rd_data   out  XLEN     MPRF write data
//  wa_init_done      out  1        sweep complete, arbiter in RUN
// BEHAVIOUR
//  Reset state (rst high):
//   - State INIT (RUN if INIT_EN=0); sweep counter = 1; busy[] = 0; starve counter = 0.
//   - All outputs 0 while rst=1, incl. w_req, rdy, haz, init_done.
//   - rst mid-sweep or mid-RUN discards all state; the sweep restarts from x1 and
//     reservations are lost.
//  INIT:
//   - w_req=1, rd_addr=counter, rd_data=0; counter increments each cycle.
//   - After writing NREGS-1 the FSM goes to RUN, so INIT lasts NREGS-1 cycles.
//   - rdy=0 and haz=0 throughout; rsv is ignored.
//  RUN, per cycle (combinational grant, zero latency):
//   - The write lands in the MPRF at the next posedge.
//   - Normal: LSU wins if lsu2wa_req, else EXU wins if exu2wa_req.
//   - When starve_cnt == STARVE_MAX, EXU wins over LSU for one cycle.
//   - Both rdy outputs follow the grant; rdy is asserted only for the requester
//     that is granted.
//   - w_req = grant; addr and data are muxed from the winner.
//   - A request with addr==0 is still granted and handshaked, but w_req=0.
//   - starve_cnt: +1 when exu_req is high and not granted; cleared on an EXU grant
//     or when exu_req is low; saturates at STARVE_MAX.
//  Scoreboard:
//   - busy[a] is set on lsu2wa_rsv with a!=0.
//   - busy[a] is cleared when an LSU grant is made to a.
//   - Set and clear to the same addr in one cycle: set wins.
//   - EXU writes never change busy.
//   - haz = busy[rs] (registered bits, combinational lookup); rs==0 -> haz=0.
//   - A load commit in cycle t drops haz in cycle t+1.
//   - rsv while busy[a] is already 1: stays 1 (no counting).
//   - Requesters hold req/addr/data stable until rdy.
//  wa_init_done: 1 from the first RUN cycle until reset.
// STRUCTURE
//  - type_scr1_wa_state_e {SCR1_WA_INIT, SCR1_WA_RUN} and the grant encoding
//    type_scr1_wa_gnt_e {NONE, EXU, LSU} go in scr1_arch_types.svh.
//  - Defaults for STARVE_MAX and INIT_EN go in scr1_arch_description.svh.
//  - Sub-module scr1_pipe_mprf_sboard: busy register, set/clear logic and the
//    two hazard lookup ports.
//  - Top level: FSM, sweep counter, arbiter, starve counter, output mux.
// TESTING
//  1. Release rst, INIT_EN=1, AW=5 -> 31 cycles of w_req with addr 1..31 and
//     data 0; init_done rises in cycle 32; no rdy during the sweep.
//  2. RUN, EXU only: addr=3, data=0xA5A5A5A5 -> same-cycle rdy/w_req; rs1=3 reads
//     0xA5A5A5A5 next cycle. EXU write with addr 0 -> rdy=1, w_req=0.
//  3. LSU and EXU both held high, STARVE_MAX=4 -> LSU granted 4 cycles, EXU on
//     the 5th, then LSU again.
//  4. rsv addr 7 -> rs2=7 gives haz=1; LSU commit to 7 -> haz=0 next cycle.
//     rsv and commit to 7 in the same cycle -> haz stays 1.
//  5. Assert rst at sweep addr 15 -> outputs 0 immediately; after release, the
//     sweep restarts at 1. Assert rst in RUN with busy[5]=1 -> haz for 5 = 0.
//  6. INIT_EN=0 -> init_done=1 and EXU grant possible in the first cycle after
//     rst falls.

Source files
------------

// File: rtl/scr1_pipe_mprf_wrarb_pkg.sv
// Shared types and defaults for the MPRF write-port arbiter and its busy scoreboard.
// No logic here besides a small saturating-increment helper.
package scr1_pipe_mprf_wrarb_pkg;

  localparam int unsigned SCR1_WA_STARVE_MAX_DEF = 4;
  localparam bit          SCR1_WA_INIT_EN_DEF    = 1'b1;
  localparam int unsigned SCR1_WA_STARVE_W       = 4;

  typedef enum logic {
    SCR1_WA_INIT,
    SCR1_WA_RUN
  } type_scr1_wa_state_e;

  typedef enum logic [1:0] {
    SCR1_WA_GNT_NONE,
    SCR1_WA_GNT_EXU,
    SCR1_WA_GNT_LSU
  } type_scr1_wa_gnt_e;

  function automatic logic [SCR1_WA_STARVE_W-1:0] scr1_wa_sat_inc(
    input logic [SCR1_WA_STARVE_W-1:0] val,
    input logic [SCR1_WA_STARVE_W-1:0] lim
  );
    return (val >= lim) ? lim : val + 1'b1;
  endfunction

endpackage

// File: rtl/scr1_pipe_mprf_wrarb_sboard.sv
// Pending-load busy bits: set on reservation, cleared on LSU commit (set wins), 1-cycle update.
// Hazard lookups are combinational on the registered bits; no backpressure.
module scr1_pipe_mprf_sboard #(
  parameter int MPRF_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [MPRF_AW-1:0] set_addr,
  input  logic               clr_en,
  input  logic [MPRF_AW-1:0] clr_addr,
  input  logic [MPRF_AW-1:0] rs1_addr,
  input  logic [MPRF_AW-1:0] rs2_addr,
  output logic               rs1_busy,
  output logic               rs2_busy
);

  localparam int NREGS = 2 ** MPRF_AW;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear first so a same-cycle reservation of the committing register survives.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = (rs1_addr != '0) & busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != '0) & busy_q[rs2_addr];

endmodule

// File: rtl/scr1_pipe_mprf_wrarb.sv
// MPRF write-port master: post-reset zero sweep, then LSU-priority arbitration with EXU anti-starvation.
// Zero-latency grant; the loser is simply not handshaked (rdy low) and must hold its request.
module scr1_pipe_mprf_wrarb
  import scr1_pipe_mprf_wrarb_pkg::*;
#(
  parameter int unsigned MPRF_AW    = 5,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = SCR1_WA_STARVE_MAX_DEF,
  parameter bit          INIT_EN    = SCR1_WA_INIT_EN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exu2wa_req,
  input  logic [MPRF_AW-1:0] exu2wa_addr,
  input  logic [XLEN-1:0]    exu2wa_data,
  output logic               wa2exu_rdy,
  input  logic               lsu2wa_req,
  input  logic [MPRF_AW-1:0] lsu2wa_addr,
  input  logic [XLEN-1:0]    lsu2wa_data,
  output logic               wa2lsu_rdy,
  input  logic               lsu2wa_rsv,
  input  logic [MPRF_AW-1:0] lsu2wa_rsv_addr,
  input  logic [MPRF_AW-1:0] exu2wa_rs1_addr,
  input  logic [MPRF_AW-1:0] exu2wa_rs2_addr,
  output logic               wa2exu_rs1_haz,
  output logic               wa2exu_rs2_haz,
  output logic               wa2mprf_w_req,
  output logic [MPRF_AW-1:0] wa2mprf_rd_addr,
  output logic [XLEN-1:0]    wa2mprf_rd_data,
  output logic               wa_init_done
);

  localparam int NREGS = 2 ** MPRF_AW;
  localparam logic [MPRF_AW-1:0]          LAST_ADDR  = MPRF_AW'(NREGS - 1);
  localparam logic [SCR1_WA_STARVE_W-1:0] STARVE_LIM = SCR1_WA_STARVE_W'(STARVE_MAX);
  localparam type_scr1_wa_state_e RST_STATE = INIT_EN ? SCR1_WA_INIT : SCR1_WA_RUN;

  type_scr1_wa_state_e             state_q;
  type_scr1_wa_state_e             state_d;
  type_scr1_wa_gnt_e               gnt;
  logic [MPRF_AW-1:0]              sweep_q;
  logic [SCR1_WA_STARVE_W-1:0]     starve_q;
  logic                            run;
  logic                            exu_prio;
  logic                            rs1_busy;
  logic                            rs2_busy;

  assign run      = (state_q == SCR1_WA_RUN);
  assign exu_prio = (starve_q == STARVE_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == SCR1_WA_INIT) && (sweep_q == LAST_ADDR)) begin
      state_d = SCR1_WA_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_q <= MPRF_AW'(1);
    end else if (state_q == SCR1_WA_INIT) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end

  // EXU beats LSU only once it has lost STARVE_MAX times in a row.
  always_comb begin
    gnt = SCR1_WA_GNT_NONE;
    if (run) begin
      if (lsu2wa_req && !(exu_prio && exu2wa_req)) begin
        gnt = SCR1_WA_GNT_LSU;
      end else if (exu2wa_req) begin
        gnt = SCR1_WA_GNT_EXU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (run && exu2wa_req && (gnt != SCR1_WA_GNT_EXU)) begin
      starve_q <= scr1_wa_sat_inc(starve_q, STARVE_LIM);
    end else begin
      starve_q <= '0;
    end
  end

  scr1_pipe_mprf_sboard #(
    .MPRF_AW (MPRF_AW)
  ) i_sboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (run & lsu2wa_rsv),
    .set_addr (lsu2wa_rsv_addr),
    .clr_en   (gnt == SCR1_WA_GNT_LSU),
    .clr_addr (lsu2wa_addr),
    .rs1_addr (exu2wa_rs1_addr),
    .rs2_addr (exu2wa_rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  // Everything is forced low while rst is high, independent of registered state.
  always_comb begin
    wa2exu_rdy      = 1'b0;
    wa2lsu_rdy      = 1'b0;
    wa2exu_rs1_haz  = 1'b0;
    wa2exu_rs2_haz  = 1'b0;
    wa2mprf_w_req   = 1'b0;
    wa2mprf_rd_addr = '0;
    wa2mprf_rd_data = '0;
    wa_init_done    = 1'b0;
    if (!rst) begin
      if (state_q == SCR1_WA_INIT) begin
        wa2mprf_w_req   = 1'b1;
        wa2mprf_rd_addr = sweep_q;
      end else begin
        wa_init_done   = 1'b1;
        wa2exu_rs1_haz = rs1_busy;
        wa2exu_rs2_haz = rs2_busy;
        case (gnt)
          SCR1_WA_GNT_EXU: begin
            wa2exu_rdy      = 1'b1;
            wa2mprf_w_req   = (exu2wa_addr != '0);
            wa2mprf_rd_addr = exu2wa_addr;
            wa2mprf_rd_data = exu2wa_data;
          end
          SCR1_WA_GNT_LSU: begin
            wa2lsu_rdy      = 1'b1;
            wa2mprf_w_req   = (lsu2wa_addr != '0);
            wa2mprf_rd_addr = lsu2wa_addr;
            wa2mprf_rd_data = lsu2wa_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scr1_pipe_mprf_wrarb.sv
// Bench for the MPRF write arbiter: directed table, reset corner sequences, then random traffic vs a model.
module tb_scr1_pipe_mprf_wrarb;

  localparam int SM = 4;

  typedef struct packed {
    logic        rst;
    logic        exu_req;
    logic [4:0]  exu_addr;
    logic [31:0] exu_data;
    logic        lsu_req;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        rsv;
    logic [4:0]  rsv_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } in_t;

  typedef struct packed {
    logic        exu_rdy;
    logic        lsu_rdy;
    logic        rs1_haz;
    logic        rs2_haz;
    logic        w_req;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        init_done;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exu_req = 1'b0, lsu_req = 1'b0, rsv = 1'b0;
  logic [4:0]  exu_addr = '0, lsu_addr = '0, rsv_addr = '0, rs1 = '0, rs2 = '0;
  logic [31:0] exu_data = '0, lsu_data = '0;

  logic        o0_exu_rdy, o0_lsu_rdy, o0_h1, o0_h2, o0_wreq, o0_done;
  logic [4:0]  o0_addr;
  logic [31:0] o0_data;
  logic        o1_exu_rdy, o1_lsu_rdy, o1_h1, o1_h2, o1_wreq, o1_done;
  logic [4:0]  o1_addr;
  logic [31:0] o1_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scr1_pipe_mprf_wrarb #(.MPRF_AW(5), .XLEN(32), .STARVE_MAX(SM), .INIT_EN(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .exu2wa_req(exu_req), .exu2wa_addr(exu_addr), .exu2wa_data(exu_data), .wa2exu_rdy(o0_exu_rdy),
    .lsu2wa_req(lsu_req), .lsu2wa_addr(lsu_addr), .lsu2wa_data(lsu_data), .wa2lsu_rdy(o0_lsu_rdy),
    .lsu2wa_rsv(rsv), .lsu2wa_rsv_addr(rsv_addr),
    .exu2wa_rs1_addr(rs1), .exu2wa_rs2_addr(rs2),
    .wa2exu_rs1_haz(o0_h1), .wa2exu_rs2_haz(o0_h2),
    .wa2mprf_w_req(o0_wreq), .wa2mprf_rd_addr(o0_addr), .wa2mprf_rd_data(o0_data),
    .wa_init_done(o0_done)
  );

  scr1_pipe_mprf_wrarb #(.MPRF_AW(5), .XLEN(32), .STARVE_MAX(SM), .INIT_EN(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .exu2wa_req(exu_req), .exu2wa_addr(exu_addr), .exu2wa_data(exu_data), .wa2exu_rdy(o1_exu_rdy),
    .lsu2wa_req(lsu_req), .lsu2wa_addr(lsu_addr), .lsu2wa_data(lsu_data), .wa2lsu_rdy(o1_lsu_rdy),
    .lsu2wa_rsv(rsv), .lsu2wa_rsv_addr(rsv_addr),
    .exu2wa_rs1_addr(rs1), .exu2wa_rs2_addr(rs2),
    .wa2exu_rs1_haz(o1_h1), .wa2exu_rs2_haz(o1_h2),
    .wa2mprf_w_req(o1_wreq), .wa2mprf_rd_addr(o1_addr), .wa2mprf_rd_data(o1_data),
    .wa_init_done(o1_done)
  );

  function automatic in_t mk_in(input bit er, input logic [4:0] ea, input logic [31:0] ed,
                                input bit lr, input logic [4:0] la, input logic [31:0] ld,
                                input bit rv, input logic [4:0] ra,
                                input logic [4:0] r1, input logic [4:0] r2);
    in_t v;
    v = '{rst: 1'b0, exu_req: er, exu_addr: ea, exu_data: ed, lsu_req: lr, lsu_addr: la,
          lsu_data: ld, rsv: rv, rsv_addr: ra, rs1: r1, rs2: r2};
    return v;
  endfunction

  function automatic out_t mk_out(input bit erdy, input bit lrdy, input bit h1, input bit h2,
                                  input bit wr, input logic [4:0] a, input logic [31:0] d);
    out_t o;
    o = '{exu_rdy: erdy, lsu_rdy: lrdy, rs1_haz: h1, rs2_haz: h2, w_req: wr, addr: a,
          data: d, init_done: 1'b1};
    return o;
  endfunction

  function automatic out_t sweep_out(input int i);
    out_t o;
    o = '0;
    o.w_req = 1'b1;
    o.addr  = 5'(i);
    return o;
  endfunction

  function automatic out_t dut_out(input bit which);
    out_t o;
    if (!which) o = {o0_exu_rdy, o0_lsu_rdy, o0_h1, o0_h2, o0_wreq, o0_addr, o0_data, o0_done};
    else        o = {o1_exu_rdy, o1_lsu_rdy, o1_h1, o1_h2, o1_wreq, o1_addr, o1_data, o1_done};
    return o;
  endfunction

  task automatic drive(input in_t v);
    @(negedge clk);
    rst      = v.rst;
    exu_req  = v.exu_req;  exu_addr = v.exu_addr;  exu_data = v.exu_data;
    lsu_req  = v.lsu_req;  lsu_addr = v.lsu_addr;  lsu_data = v.lsu_data;
    rsv      = v.rsv;      rsv_addr = v.rsv_addr;
    rs1      = v.rs1;      rs2      = v.rs2;
    #1;
  endtask

  task automatic check(input string name, input int idx, input bit which, input out_t exp);
    out_t act;
    act = dut_out(which);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] dut%0d got=%h want=%h", name, idx, which, act, exp);
    end
  endtask

  task automatic sweep_chk(input string name, input int n);
    for (int i = 1; i <= n; i++) begin
      drive('0);
      check(name, i, 1'b0, sweep_out(i));
    end
  endtask

  task automatic rst_chk(input string name);
    in_t v;
    v = '0;
    v.rst = 1'b1;
    drive(v);
    check(name, 0, 1'b0, '0);
  endtask

  // Reference model: architectural state kept as plain counters and a bit array.
  bit m_run;
  int m_sweep;
  int m_starve;
  bit m_busy[32];

  function automatic out_t model_eval(input in_t v);
    out_t e;
    bit   exu_win, lsu_win;
    e = '0;
    if (v.rst) return e;
    if (!m_run) return sweep_out(m_sweep);
    e.init_done = 1'b1;
    e.rs1_haz   = (v.rs1 != 0) && m_busy[v.rs1];
    e.rs2_haz   = (v.rs2 != 0) && m_busy[v.rs2];
    exu_win = v.exu_req && (!v.lsu_req || m_starve == SM);
    lsu_win = v.lsu_req && !exu_win;
    if (exu_win) begin
      e.exu_rdy = 1'b1; e.w_req = (v.exu_addr != 0); e.addr = v.exu_addr; e.data = v.exu_data;
    end else if (lsu_win) begin
      e.lsu_rdy = 1'b1; e.w_req = (v.lsu_addr != 0); e.addr = v.lsu_addr; e.data = v.lsu_data;
    end
    return e;
  endfunction

  task automatic model_step(input in_t v, input out_t e);
    if (v.rst) begin
      m_run = 1'b0; m_sweep = 1; m_starve = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else if (!m_run) begin
      if (m_sweep == 31) m_run = 1'b1;
      m_sweep++;
    end else begin
      if (e.lsu_rdy) m_busy[v.lsu_addr] = 1'b0;
      if (v.rsv && v.rsv_addr != 0) m_busy[v.rsv_addr] = 1'b1;
      if (v.exu_req && !e.exu_rdy) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
      else m_starve = 0;
    end
  endtask

  vec_t tbl[$];

  initial begin
    in_t  v;
    out_t e;
    bit   pend_exu, pend_lsu;

    // Directed RUN-phase table, applied right after the first sweep.
    tbl.push_back('{mk_in(1, 3, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 1, 3, 32'hA5A5A5A5)});
    tbl.push_back('{mk_in(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0),     mk_out(1, 0, 0, 0, 0, 0, 32'h1234)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 7),             mk_out(0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 7),             mk_out(0, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 1, 7, 32'hDEAD0007, 0, 0, 0, 7),  mk_out(0, 1, 0, 1, 1, 7, 32'hDEAD0007)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 7),             mk_out(0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0),             mk_out(0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 7),             mk_out(0, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 1, 7, 32'h77, 1, 7, 0, 7),        mk_out(0, 1, 0, 1, 1, 7, 32'h77)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 7),             mk_out(0, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{mk_in(0, 0, 0, 1, 7, 32'h78, 0, 0, 0, 7),        mk_out(0, 1, 0, 1, 1, 7, 32'h78)});
    tbl.push_back('{mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 7),             mk_out(0, 0, 0, 0, 0, 0, 0)});
    for (int k = 0; k < 6; k++)
      tbl.push_back('{mk_in(1, 5, 32'hEEEE0005, 1, 4, 32'h11110004, 0, 0, 0, 0),
                      (k == 4) ? mk_out(1, 0, 0, 0, 1, 5, 32'hEEEE0005)
                               : mk_out(0, 1, 0, 0, 1, 4, 32'h11110004)});
    tbl.push_back('{mk_in(0, 0, 0, 1, 0, 32'h5, 0, 0, 0, 0),         mk_out(0, 1, 0, 0, 0, 0, 32'h5)});
    for (int k = 0; k < 5; k++)
      tbl.push_back('{mk_in(1, 6, 32'h66, 1, 8, 32'h88, 0, 0, 0, 0),
                      (k == 4) ? mk_out(1, 0, 0, 0, 1, 6, 32'h66)
                               : mk_out(0, 1, 0, 0, 1, 8, 32'h88)});

    // Reset values, then the sweep with EXU and a reservation pending throughout.
    rst_chk("reset");
    check("reset_noinit", 0, 1'b1, '0);
    for (int i = 1; i <= 31; i++) begin
      drive(mk_in(1, 2, 32'h22, 0, 0, 0, 1, 9, 0, 0));
      check("sweep", i, 1'b0, sweep_out(i));
      if (i == 1) check("noinit_first", 0, 1'b1, mk_out(1, 0, 0, 0, 1, 2, 32'h22));
    end
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 9, 0));
    check("run_entry", 32, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      check("table", i, 1'b0, tbl[i].exp);
    end

    // Reset in the middle of the sweep, then reset with a live reservation.
    rst_chk("reset2");
    sweep_chk("sweep_a", 14);
    rst_chk("reset_mid_sweep");
    sweep_chk("sweep_b", 31);
    drive(mk_in(0, 0, 0, 0, 0, 0, 1, 5, 0, 0));
    check("rsv5", 0, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0));
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
    check("haz5", 0, 1'b0, mk_out(0, 0, 1, 0, 0, 0, 0));
    rst_chk("reset_run");
    sweep_chk("sweep_c", 31);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
    check("haz5_lost", 0, 1'b0, mk_out(0, 0, 0, 0, 0, 0, 0));

    // Random traffic; requesters hold until handshaked.
    v = '0;
    v.rst = 1'b1;
    e = model_eval(v);
    drive(v);
    check("rand_rst", 0, 1'b0, e);
    model_step(v, e);
    pend_exu = 1'b0;
    pend_lsu = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      v.rst = ($urandom_range(0, 399) == 0);
      if (!pend_exu) begin
        v.exu_req  = $urandom_range(0, 1) == 1;
        v.exu_addr = 5'($urandom_range(0, 7));
        v.exu_data = $urandom;
      end
      if (!pend_lsu) begin
        v.lsu_req  = $urandom_range(0, 2) != 0;
        v.lsu_addr = 5'($urandom_range(0, 7));
        v.lsu_data = $urandom;
      end
      v.rsv      = $urandom_range(0, 3) == 0;
      v.rsv_addr = 5'($urandom_range(0, 7));
      v.rs1      = 5'($urandom_range(0, 7));
      v.rs2      = 5'($urandom_range(0, 7));
      e = model_eval(v);
      drive(v);
      check("rand", k, 1'b0, e);
      model_step(v, e);
      pend_exu = !v.rst && v.exu_req && !e.exu_rdy;
      pend_lsu = !v.rst && v.lsu_req && !e.lsu_rdy;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
